trace_transition_checker: RTL

- Parametrised successor to the neighbour tracker in the attestation pipeline; sits after the trace-to-index mapping stage.
- Keeps a per-index successor bitmap table and runs in LEARN mode (record transitions) or CHECK mode (flag unseen transitions).
- Emits the updated bitmap, a violation flag, a saturating violation counter and a capture of the first offending trace.
- Self-clears its table after reset and on command.

---
 rtl/trace_transition_checker_if.sv | 32 +++
 rtl/trace_transition_checker.sv | 132 +++++++++++++
 2 files changed

// File: rtl/trace_transition_checker_if.sv
// trace_transition_checker_if: event input and result bus of the transition checker
interface trace_transition_checker_if #(
  parameter int TRACE_W = 32,
  parameter int IDX_W   = 13,
  parameter int NBR     = 8,
  parameter int CNT_W   = 16
);
  logic               index_valid;
  logic [IDX_W-1:0]   index;
  logic [TRACE_W-1:0] trace;
  logic               mode;
  logic               clear;
  logic               in_ready;
  logic               busy;
  logic               out_valid;
  logic [NBR-1:0]     neighbours;
  logic               violation;
  logic [CNT_W-1:0]   viol_count;
  logic               viol_sticky;
  logic [TRACE_W-1:0] viol_trace;
  logic [IDX_W-1:0]   viol_prev;
  modport master (
    output index_valid, index, trace, mode, clear,
    input  in_ready, busy, out_valid, neighbours, violation,
           viol_count, viol_sticky, viol_trace, viol_prev
  );
  modport slave (
    input  index_valid, index, trace, mode, clear,
    output in_ready, busy, out_valid, neighbours, violation,
           viol_count, viol_sticky, viol_trace, viol_prev
  );
endinterface

// File: rtl/trace_transition_checker.sv
// trace_transition_checker: learns index-to-index transitions and flags unseen ones
module trace_transition_checker #(
  parameter int TRACE_W = 32,
  parameter int IDX_W   = 13,
  parameter int NBR     = 8,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  trace_transition_checker_if.slave bus
);
  localparam int SW    = $clog2(NBR);
  localparam int DEPTH = 1 << IDX_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               busy, in_ready, accept, miss, cap, wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [NBR-1:0]     wr_data, rd, mask, nw;
  logic [NBR-1:0]     mem [DEPTH];
  logic [NBR-1:0]     rd_q;
  logic               byp_q, byp_d;
  logic [NBR-1:0]     byp_data_q, byp_data_d;
  logic               have_prev_q, have_prev_d;
  logic [IDX_W-1:0]   prev_q, prev_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]   s1_prev_q, s1_prev_d;
  logic [SW-1:0]      s1_slot_q, s1_slot_d;
  logic [TRACE_W-1:0] s1_trace_q, s1_trace_d;
  logic               s1_mode_q, s1_mode_d;
  logic               out_valid_q, out_valid_d;
  logic [NBR-1:0]     neighbours_q, neighbours_d;
  logic               violation_q, violation_d;
  logic [CNT_W-1:0]   viol_count_q, viol_count_d;
  logic               viol_sticky_q, viol_sticky_d;
  logic [TRACE_W-1:0] viol_trace_q, viol_trace_d;
  logic [IDX_W-1:0]   viol_prev_q, viol_prev_d;
  // state register: reset lands in SWEEP so the table is wiped before use
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= SWEEP;
    else state_q <= state_d;
  // next state: sweep ends on the last address, clear only honoured in IDLE
  always_comb
    state_d = state_q == SWEEP ? (&sweep_q ? IDLE : SWEEP) : (bus.clear ? SWEEP : IDLE);
  // FSM outputs
  always_comb begin
    busy = state_q == SWEEP;
    in_ready = !busy && !bus.clear;
  end
  // table write port and synchronous read of the previous index
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[prev_q];
  end
  // datapath: accept, S1 update/check, bypass, violation capture
  always_comb begin
    accept = bus.index_valid && in_ready;
    sweep_d = busy ? sweep_q + IDX_W'(1) : '0;
    rd = byp_q ? byp_data_q : rd_q;
    mask = NBR'(1) << s1_slot_q;
    nw = s1_mode_q ? rd : (rd | mask);
    miss = s1_valid_q && s1_mode_q && !rd[s1_slot_q];
    wr_en = busy || (s1_valid_q && !s1_mode_q);
    wr_addr = busy ? sweep_q : s1_prev_q;
    wr_data = busy ? '0 : nw;
    byp_d = s1_valid_q && !s1_mode_q && s1_prev_q == prev_q;
    byp_data_d = nw;
    have_prev_d = !busy && (accept || have_prev_q);
    prev_d = accept ? bus.index : prev_q;
    s1_valid_d = accept && have_prev_q;
    s1_prev_d = accept ? prev_q : s1_prev_q;
    s1_slot_d = accept ? bus.index[SW-1:0] : s1_slot_q;
    s1_trace_d = accept ? bus.trace : s1_trace_q;
    s1_mode_d = accept ? bus.mode : s1_mode_q;
    out_valid_d = s1_valid_q;
    neighbours_d = s1_valid_q ? nw : neighbours_q;
    violation_d = miss;
    cap = miss && !viol_sticky_q;
    viol_count_d = busy ? '0 : (miss && !(&viol_count_q)) ? viol_count_q + CNT_W'(1) : viol_count_q;
    viol_sticky_d = !busy && (miss || viol_sticky_q);
    viol_trace_d = busy ? '0 : cap ? s1_trace_q : viol_trace_q;
    viol_prev_d = busy ? '0 : cap ? s1_prev_q : viol_prev_q;
  end
  // pipeline and result registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sweep_q <= '0;
      byp_q <= 1'b0;
      byp_data_q <= '0;
      have_prev_q <= 1'b0;
      prev_q <= '0;
      s1_valid_q <= 1'b0;
      s1_prev_q <= '0;
      s1_slot_q <= '0;
      s1_trace_q <= '0;
      s1_mode_q <= 1'b0;
      out_valid_q <= 1'b0;
      neighbours_q <= '0;
      violation_q <= 1'b0;
      viol_count_q <= '0;
      viol_sticky_q <= 1'b0;
      viol_trace_q <= '0;
      viol_prev_q <= '0;
    end else begin
      sweep_q <= sweep_d;
      byp_q <= byp_d;
      byp_data_q <= byp_data_d;
      have_prev_q <= have_prev_d;
      prev_q <= prev_d;
      s1_valid_q <= s1_valid_d;
      s1_prev_q <= s1_prev_d;
      s1_slot_q <= s1_slot_d;
      s1_trace_q <= s1_trace_d;
      s1_mode_q <= s1_mode_d;
      out_valid_q <= out_valid_d;
      neighbours_q <= neighbours_d;
      violation_q <= violation_d;
      viol_count_q <= viol_count_d;
      viol_sticky_q <= viol_sticky_d;
      viol_trace_q <= viol_trace_d;
      viol_prev_q <= viol_prev_d;
    end
  assign bus.in_ready = in_ready;
  assign bus.busy = busy;
  assign bus.out_valid = out_valid_q;
  assign bus.neighbours = neighbours_q;
  assign bus.violation = violation_q;
  assign bus.viol_count = viol_count_q;
  assign bus.viol_sticky = viol_sticky_q;
  assign bus.viol_trace = viol_trace_q;
  assign bus.viol_prev = viol_prev_q;
endmodule
